// File: rtl/tl_pkg.sv
// Shared TileLink-UL constants, beat-count helpers and the channel-A arbiter state encoding.
package tl_pkg;

    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get            = 3'd4;

    localparam logic [3:0] AccessAck      = 4'd0;
    localparam logic [3:0] AccessAckData  = 4'd1;

    typedef enum logic [1:0] {
        StIdle,
        StLock,
        StBurst
    } arb_state_e;

    // Messages no wider than one data beat still take a single beat.
    function automatic int unsigned beats_from_size(input int unsigned size,
                                                    input int unsigned bytes_log2);
        if (size > bytes_log2) begin
            return 32'd1 << (size - bytes_log2);
        end
        return 32'd1;
    endfunction

    function automatic int unsigned a_beats(input logic [2:0] opcode,
                                            input int unsigned size,
                                            input int unsigned bytes_log2);
        if (opcode == PutFullData || opcode == PutPartialData) begin
            return beats_from_size(size, bytes_log2);
        end
        return 32'd1;
    endfunction

endpackage

// File: rtl/tl_a_arbiter2_rr.sv
// Two-way round-robin picker with a per-requester mask; the pointer side wins ties.
module tl_rr_arb2 (
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       ptr,
    output logic       valid,
    output logic       gnt
);

    logic [1:0] req_m;

    assign req_m = req & ~mask;
    assign valid = |req_m;
    assign gnt   = req_m[ptr] ? ptr : ~ptr;

endmodule

// File: rtl/tl_a_arbiter2.sv
// Two-master to one-slave TileLink-UL arbiter: round-robin channel A with message locking,
// channel D routed by the source MSB. Define TL_ARB_OUTSTANDING_EN for per-master limits.
`ifndef TL_DW
`define TL_DW 64
`endif
`ifndef TL_AW
`define TL_AW 32
`endif
`ifndef TL_AIW
`define TL_AIW 4
`endif
`ifndef TL_SZW
`define TL_SZW 4
`endif
`ifndef TL_DIW
`define TL_DIW 2
`endif

module tl_a_arbiter2
    import tl_pkg::*;
#(
    parameter int unsigned DW  = `TL_DW,
    parameter int unsigned AW  = `TL_AW,
    parameter int unsigned AIW = `TL_AIW,
    parameter int unsigned SZW = `TL_SZW,
    parameter int unsigned DIW = `TL_DIW
`ifdef TL_ARB_OUTSTANDING_EN
    , parameter int unsigned MAX_OUT = 4
`endif
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_a_valid,
    output logic              m0_a_ready,
    input  logic [2:0]        m0_a_opcode,
    input  logic [2:0]        m0_a_param,
    input  logic [SZW-1:0]    m0_a_size,
    input  logic [AIW-1:0]    m0_a_source,
    input  logic [AW-1:0]     m0_a_address,
    input  logic [DW/8-1:0]   m0_a_mask,
    input  logic [DW-1:0]     m0_a_data,
    input  logic              m0_a_corrupt,

    input  logic              m1_a_valid,
    output logic              m1_a_ready,
    input  logic [2:0]        m1_a_opcode,
    input  logic [2:0]        m1_a_param,
    input  logic [SZW-1:0]    m1_a_size,
    input  logic [AIW-1:0]    m1_a_source,
    input  logic [AW-1:0]     m1_a_address,
    input  logic [DW/8-1:0]   m1_a_mask,
    input  logic [DW-1:0]     m1_a_data,
    input  logic              m1_a_corrupt,

    output logic              m0_d_valid,
    input  logic              m0_d_ready,
    output logic [3:0]        m0_d_opcode,
    output logic [1:0]        m0_d_param,
    output logic [SZW-1:0]    m0_d_size,
    output logic [AIW-1:0]    m0_d_source,
    output logic [DIW-1:0]    m0_d_sink,
    output logic              m0_d_denied,
    output logic [DW-1:0]     m0_d_data,
    output logic              m0_d_corrupt,

    output logic              m1_d_valid,
    input  logic              m1_d_ready,
    output logic [3:0]        m1_d_opcode,
    output logic [1:0]        m1_d_param,
    output logic [SZW-1:0]    m1_d_size,
    output logic [AIW-1:0]    m1_d_source,
    output logic [DIW-1:0]    m1_d_sink,
    output logic              m1_d_denied,
    output logic [DW-1:0]     m1_d_data,
    output logic              m1_d_corrupt,

    output logic              s0_a_valid,
    input  logic              s0_a_ready,
    output logic [2:0]        s0_a_opcode,
    output logic [2:0]        s0_a_param,
    output logic [SZW-1:0]    s0_a_size,
    output logic [AIW:0]      s0_a_source,
    output logic [AW-1:0]     s0_a_address,
    output logic [DW/8-1:0]   s0_a_mask,
    output logic [DW-1:0]     s0_a_data,
    output logic              s0_a_corrupt,

    input  logic              s0_d_valid,
    output logic              s0_d_ready,
    input  logic [3:0]        s0_d_opcode,
    input  logic [1:0]        s0_d_param,
    input  logic [SZW-1:0]    s0_d_size,
    input  logic [AIW:0]      s0_d_source,
    input  logic [DIW-1:0]    s0_d_sink,
    input  logic              s0_d_denied,
    input  logic [DW-1:0]     s0_d_data,
    input  logic              s0_d_corrupt
);

    localparam int unsigned LogBytes = $clog2(DW / 8);

    arb_state_e     state_q, state_d;
    logic           grant_q, grant_d;
    logic           rr_ptr_q, rr_ptr_d;
    logic [SZW-1:0] remaining_q, remaining_d;

    logic [1:0]     out_mask;
    logic           arb_valid, arb_gnt;
    logic           sel;
    logic           sel_valid;
    logic           a_fire;
    int unsigned    a_beats_cur;
    logic           d_sel;

    tl_rr_arb2 u_rr_arb (
        .req   ({m1_a_valid, m0_a_valid}),
        .mask  (out_mask),
        .ptr   (rr_ptr_q),
        .valid (arb_valid),
        .gnt   (arb_gnt)
    );

    // Outside IDLE the registered grant keeps the slave-visible payload stable.
    assign sel       = (state_q == StIdle) ? arb_gnt : grant_q;
    assign sel_valid = sel ? m1_a_valid : m0_a_valid;

    assign s0_a_valid   = !rst && ((state_q == StIdle) ? arb_valid : sel_valid);
    assign s0_a_opcode  = sel ? m1_a_opcode  : m0_a_opcode;
    assign s0_a_param   = sel ? m1_a_param   : m0_a_param;
    assign s0_a_size    = sel ? m1_a_size    : m0_a_size;
    assign s0_a_source  = {sel, (sel ? m1_a_source : m0_a_source)};
    assign s0_a_address = sel ? m1_a_address : m0_a_address;
    assign s0_a_mask    = sel ? m1_a_mask    : m0_a_mask;
    assign s0_a_data    = sel ? m1_a_data    : m0_a_data;
    assign s0_a_corrupt = sel ? m1_a_corrupt : m0_a_corrupt;

    assign m0_a_ready = s0_a_valid && s0_a_ready && !sel;
    assign m1_a_ready = s0_a_valid && s0_a_ready && sel;
    assign a_fire     = s0_a_valid && s0_a_ready;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        remaining_d = remaining_q;
        a_beats_cur = a_beats(s0_a_opcode, 32'(s0_a_size), LogBytes);
        unique case (state_q)
            StIdle, StLock: begin
                if (s0_a_valid) begin
                    grant_d = sel;
                    if (s0_a_ready) begin
                        if (a_beats_cur > 32'd1) begin
                            state_d     = StBurst;
                            remaining_d = SZW'(a_beats_cur - 32'd1);
                        end else begin
                            state_d  = StIdle;
                            rr_ptr_d = ~sel;
                        end
                    end else begin
                        state_d = StLock;
                    end
                end
            end
            StBurst: begin
                if (a_fire) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == SZW'(1)) begin
                        state_d  = StIdle;
                        rr_ptr_d = ~grant_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_q     <= 1'b0;
            rr_ptr_q    <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            remaining_q <= remaining_d;
        end
    end

    // Channel D: pure routing on the prepended master-index bit.
    assign d_sel      = s0_d_source[AIW];
    assign s0_d_ready = d_sel ? m1_d_ready : m0_d_ready;

    assign m0_d_valid   = !rst && s0_d_valid && !d_sel;
    assign m0_d_opcode  = s0_d_opcode;
    assign m0_d_param   = s0_d_param;
    assign m0_d_size    = s0_d_size;
    assign m0_d_source  = s0_d_source[AIW-1:0];
    assign m0_d_sink    = s0_d_sink;
    assign m0_d_denied  = s0_d_denied;
    assign m0_d_data    = s0_d_data;
    assign m0_d_corrupt = s0_d_corrupt;

    assign m1_d_valid   = !rst && s0_d_valid && d_sel;
    assign m1_d_opcode  = s0_d_opcode;
    assign m1_d_param   = s0_d_param;
    assign m1_d_size    = s0_d_size;
    assign m1_d_source  = s0_d_source[AIW-1:0];
    assign m1_d_sink    = s0_d_sink;
    assign m1_d_denied  = s0_d_denied;
    assign m1_d_data    = s0_d_data;
    assign m1_d_corrupt = s0_d_corrupt;

`ifdef TL_ARB_OUTSTANDING_EN
    localparam int unsigned CntW = $clog2(MAX_OUT + 1);

    logic [CntW-1:0] out_cnt_q [2];
    logic [CntW-1:0] out_cnt_d [2];
    logic [SZW-1:0]  d_beat_q, d_beat_d;
    int unsigned     d_beats_cur;
    logic            a_last, d_fire, d_last;

    assign a_last = a_fire && ((state_q == StBurst) ? (remaining_q == SZW'(1))
                                                    : (a_beats_cur <= 32'd1));
    assign d_fire = s0_d_valid && s0_d_ready;
    assign d_beats_cur = (s0_d_opcode == AccessAckData) ?
                         beats_from_size(32'(s0_d_size), LogBytes) : 32'd1;
    assign d_last = d_fire && (32'(d_beat_q) == d_beats_cur - 32'd1);

    always_comb begin
        d_beat_d = d_beat_q;
        if (d_last) begin
            d_beat_d = '0;
        end else if (d_fire) begin
            d_beat_d = d_beat_q + 1'b1;
        end
        for (int n = 0; n < 2; n++) begin
            out_cnt_d[n] = out_cnt_q[n];
            if ((a_last && (sel == n[0])) && !(d_last && (d_sel == n[0]))) begin
                out_cnt_d[n] = out_cnt_q[n] + 1'b1;
            end else if (!(a_last && (sel == n[0])) && (d_last && (d_sel == n[0]))) begin
                out_cnt_d[n] = out_cnt_q[n] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_beat_q     <= '0;
            out_cnt_q[0] <= '0;
            out_cnt_q[1] <= '0;
        end else begin
            d_beat_q     <= d_beat_d;
            out_cnt_q[0] <= out_cnt_d[0];
            out_cnt_q[1] <= out_cnt_d[1];
        end
    end

    // Only IDLE arbitration is masked; a locked or bursting message still completes.
    assign out_mask = {out_cnt_q[1] == CntW'(MAX_OUT), out_cnt_q[0] == CntW'(MAX_OUT)};
`else
    assign out_mask = 2'b00;
`endif

endmodule
